// File: rtl/wm_program_sequencer.sv
// rtl/wm_program_sequencer.sv - program-aware washing-machine cycle sequencer
// Latches a wash program at start and times each phase from a per-program duration table.
module wm_program_sequencer #(
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_button,
  input  logic       pause_button,
  input  logic       door_closed,
  input  logic       water_full,
  input  logic [1:0] prog_sel,
  output logic [2:0] phase,
  output logic       valve_on,
  output logic       motor_on,
  output logic       drain_on,
  output logic       paused,
  output logic       fault,
  output logic       out
);

  typedef enum logic [2:0] {
    S_OFF   = 3'b000,
    S_FILL  = 3'b001,
    S_WASH  = 3'b010,
    S_DRAIN = 3'b011,
    S_RINSE = 3'b100,
    S_SPIN  = 3'b101,
    S_DONE  = 3'b110,
    S_FAULT = 3'b111
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       rinse_cnt_q, rinse_cnt_d;
  logic [1:0]       prog_q, prog_d;
  logic             pause_q, pause_d;
  logic             run;
  logic             last;

  function automatic logic is_timed(input state_t st);
    return (st >= S_FILL) && (st <= S_SPIN);
  endfunction

  // Program 2'b11 aliases to normal via the default arms.
  function automatic logic [CNT_W-1:0] dur(input logic [1:0] prog, input state_t st);
    logic [CNT_W-1:0] d;
    d = '0;
    case (prog)
      2'b00: case (st)
        S_FILL:  d = CNT_W'(4);
        S_WASH:  d = CNT_W'(6);
        S_DRAIN: d = CNT_W'(3);
        S_RINSE: d = CNT_W'(3);
        S_SPIN:  d = CNT_W'(4);
        default: d = '0;
      endcase
      2'b10: case (st)
        S_FILL:  d = CNT_W'(8);
        S_WASH:  d = CNT_W'(15);
        S_DRAIN: d = CNT_W'(5);
        S_RINSE: d = CNT_W'(7);
        S_SPIN:  d = CNT_W'(8);
        default: d = '0;
      endcase
      default: case (st)
        S_FILL:  d = CNT_W'(6);
        S_WASH:  d = CNT_W'(10);
        S_DRAIN: d = CNT_W'(4);
        S_RINSE: d = CNT_W'(5);
        S_SPIN:  d = CNT_W'(6);
        default: d = '0;
      endcase
    endcase
    return d;
  endfunction

  function automatic logic [2:0] passes(input logic [1:0] prog);
    case (prog)
      2'b00:   return 3'd1;
      2'b10:   return 3'd3;
      default: return 3'd2;
    endcase
  endfunction

  assign run  = is_timed(state_q) && !pause_q;
  assign last = (cnt_q == CNT_W'(1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rinse_cnt_d = rinse_cnt_q;
    prog_d      = prog_q;
    case (state_q)
      S_OFF: begin
        if (start_button && door_closed) begin
          state_d     = S_FILL;
          prog_d      = prog_sel;
          rinse_cnt_d = '0;
        end
      end
      S_FILL: begin
        if (run && water_full)  state_d = S_WASH;
        else if (run && last)   state_d = S_FAULT;
      end
      S_WASH:  if (run && last) state_d = S_DRAIN;
      S_DRAIN: if (run && last) state_d = S_RINSE;
      S_RINSE: begin
        if (run && last) begin
          if ({1'b0, rinse_cnt_q} + 3'd1 < passes(prog_q)) begin
            state_d     = S_DRAIN;
            rinse_cnt_d = rinse_cnt_q + 2'd1;
          end else begin
            state_d = S_SPIN;
          end
        end
      end
      S_SPIN:  if (run && last) state_d = S_DONE;
      S_DONE:  state_d = S_OFF;
      default: state_d = S_FAULT;
    endcase

    // No timed state transitions to itself, so any state change is an entry.
    if (state_d != state_q) begin
      cnt_d = is_timed(state_d) ? dur(prog_d, state_d) : '0;
    end else if (run) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    pause_d = is_timed(state_d) ? pause_button : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_OFF;
      cnt_q       <= '0;
      rinse_cnt_q <= '0;
      prog_q      <= '0;
      pause_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rinse_cnt_q <= rinse_cnt_d;
      prog_q      <= prog_d;
      pause_q     <= pause_d;
    end
  end

  assign phase    = state_q;
  assign valve_on = run && ((state_q == S_FILL) || (state_q == S_RINSE));
  assign motor_on = run && ((state_q == S_WASH) || (state_q == S_RINSE) || (state_q == S_SPIN));
  assign drain_on = run && ((state_q == S_DRAIN) || (state_q == S_SPIN));
  assign paused   = pause_q;
  assign fault    = (state_q == S_FAULT);
  assign out      = (state_q == S_DONE);

endmodule

// File: tb/tb_wm_program_sequencer.sv
// tb/tb_wm_program_sequencer.sv - directed self-checking bench for wm_program_sequencer
module tb_wm_program_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_button;
  logic       pause_button;
  logic       door_closed;
  logic       water_full;
  logic [1:0] prog_sel;
  logic [2:0] phase;
  logic       valve_on, motor_on, drain_on, paused, fault, out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wm_program_sequencer #(.CNT_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_button (start_button),
    .pause_button (pause_button),
    .door_closed  (door_closed),
    .water_full   (water_full),
    .prog_sel     (prog_sel),
    .phase        (phase),
    .valve_on     (valve_on),
    .motor_on     (motor_on),
    .drain_on     (drain_on),
    .paused       (paused),
    .fault        (fault),
    .out          (out)
  );

  logic [8:0] obs_vec;
  assign obs_vec = {phase, valve_on, motor_on, drain_on, paused, fault, out};

  // Expected {phase, valve, motor, drain, paused, fault, out} for a phase and pause flag.
  function automatic logic [8:0] exp_vec(input logic [2:0] ph, input logic pz);
    logic r;
    r = (ph >= 3'd1) && (ph <= 3'd5) && !pz;
    return {ph,
            r && (ph == 3'd1 || ph == 3'd4),
            r && (ph == 3'd2 || ph == 3'd4 || ph == 3'd5),
            r && (ph == 3'd3 || ph == 3'd5),
            pz,
            ph == 3'd7,
            ph == 3'd6};
  endfunction

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic expect_phase(input string tag, input logic [2:0] ph, input int n, input logic pz);
    for (int i = 0; i < n; i++) begin
      chk(tag, obs_vec, exp_vec(ph, pz));
      @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    start_button = 1'b1;
    @(negedge clk);
    start_button = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start_button = 1'b1; pause_button = 1'b1;
    door_closed = 1'b1; water_full = 1'b1; prog_sel = 2'b10;
    @(negedge clk);
    start_button = 1'b0; pause_button = 1'b0; prog_sel = 2'b01;
    @(negedge clk);
    chk("reset_state", obs_vec, exp_vec(3'd0, 1'b0));
    reset = 1'b0;
    @(negedge clk);
    chk("idle_off", obs_vec, exp_vec(3'd0, 1'b0));

    // Quick program with water already full
    prog_sel = 2'b00;
    pulse_start();
    expect_phase("q_fill",  3'd1, 1, 1'b0);
    expect_phase("q_wash",  3'd2, 6, 1'b0);
    expect_phase("q_drain", 3'd3, 3, 1'b0);
    expect_phase("q_rinse", 3'd4, 3, 1'b0);
    expect_phase("q_spin",  3'd5, 4, 1'b0);
    expect_phase("q_done",  3'd6, 1, 1'b0);
    expect_phase("q_off",   3'd0, 2, 1'b0);

    // Heavy program; prog_sel changed right after start
    prog_sel = 2'b10;
    pulse_start();
    prog_sel = 2'b00;
    expect_phase("h_fill",   3'd1, 1,  1'b0);
    expect_phase("h_wash",   3'd2, 15, 1'b0);
    expect_phase("h_drain1", 3'd3, 5,  1'b0);
    expect_phase("h_rinse1", 3'd4, 7,  1'b0);
    expect_phase("h_drain2", 3'd3, 5,  1'b0);
    expect_phase("h_rinse2", 3'd4, 7,  1'b0);
    expect_phase("h_drain3", 3'd3, 5,  1'b0);
    expect_phase("h_rinse3", 3'd4, 7,  1'b0);
    expect_phase("h_spin",   3'd5, 8,  1'b0);
    expect_phase("h_done",   3'd6, 1,  1'b0);
    expect_phase("h_off",    3'd0, 1,  1'b0);

    // Normal program, no water: fill timeout
    prog_sel = 2'b01; water_full = 1'b0;
    pulse_start();
    expect_phase("n_fill",  3'd1, 6, 1'b0);
    start_button = 1'b1;
    expect_phase("n_fault", 3'd7, 4, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("fault_reset", obs_vec, exp_vec(3'd0, 1'b0));
    reset = 1'b0; start_button = 1'b0; water_full = 1'b1;
    @(negedge clk);

    // Normal program, 10-cycle pause starting at WASH cycle 3
    prog_sel = 2'b01;
    pulse_start();
    expect_phase("p_fill", 3'd1, 1, 1'b0);
    expect_phase("p_wash_pre", 3'd2, 2, 1'b0);
    chk("p_wash_c3", obs_vec, exp_vec(3'd2, 1'b0));
    pause_button = 1'b1;
    @(negedge clk);
    expect_phase("p_wash_paused", 3'd2, 9, 1'b1);
    chk("p_wash_paused_last", obs_vec, exp_vec(3'd2, 1'b1));
    pause_button = 1'b0;
    @(negedge clk);
    expect_phase("p_wash_post", 3'd2, 7, 1'b0);
    expect_phase("p_drain", 3'd3, 1, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("p_reset", obs_vec, exp_vec(3'd0, 1'b0));
    reset = 1'b0;
    @(negedge clk);

    // Door open blocks start
    door_closed = 1'b0; start_button = 1'b1;
    expect_phase("door_open", 3'd0, 3, 1'b0);
    start_button = 1'b0; door_closed = 1'b1;
    @(negedge clk);

    // Reset mid-SPIN with pause requested
    prog_sel = 2'b00;
    pulse_start();
    expect_phase("s_fill",  3'd1, 1, 1'b0);
    expect_phase("s_wash",  3'd2, 6, 1'b0);
    expect_phase("s_drain", 3'd3, 3, 1'b0);
    expect_phase("s_rinse", 3'd4, 3, 1'b0);
    expect_phase("s_spin",  3'd5, 2, 1'b0);
    reset = 1'b1; pause_button = 1'b1;
    @(negedge clk);
    chk("spin_reset", obs_vec, exp_vec(3'd0, 1'b0));
    reset = 1'b0; pause_button = 1'b0;
    @(negedge clk);
    chk("spin_reset_idle", obs_vec, exp_vec(3'd0, 1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
